// File: rtl/bw_mult_pkg.sv
// bw_mult_pkg: shared state encoding, width helper and default operand width
package bw_mult_pkg;
  localparam int DEFAULT_N = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/bw_seq_mult_ctrl_if.sv
// bw_seq_mult_ctrl_if: start/abort/operand request and status/result bundle
interface bw_seq_mult_ctrl_if
  import bw_mult_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = log2(N)
);
  logic           start;
  logic           abort;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [CW-1:0]  row;
  modport master (output start, abort, a, b, input busy, done, product, row);
  modport slave  (input start, abort, a, b, output busy, done, product, row);
endinterface

// File: rtl/bw_row_gen.sv
// bw_row_gen: Baugh-Wooley sign handling of one partial-product row
module bw_row_gen
  import bw_mult_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = log2(N)
) (
  input  logic [N-1:0]  pp,
  input  logic [CW-1:0] row,
  output logic [N:0]    word
);
  // the leading 1s of rows 0 and N-1 supply the 2^N and 2^(2N-1) correction constants
  always_comb
    word = (row == '0) ? {1'b1, ~pp[N-1], pp[N-2:0]} :
           (row == CW'(N-1)) ? {1'b1, pp[N-1], ~pp[N-2:0]} :
           {1'b0, ~pp[N-1], pp[N-2:0]};
endmodule

// File: rtl/bw_seq_mult_ctrl.sv
// bw_seq_mult_ctrl: one-row-per-cycle signed Baugh-Wooley multiplier with start/abort control
module bw_seq_mult_ctrl
  import bw_mult_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = log2(N)
) (
  input logic              clk,
  input logic              rst_n,
  bw_seq_mult_ctrl_if.slave bus
);
  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, pp;
  logic [2*N-1:0] acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]  row_q, row_d;
  logic [N:0]     word;
  logic           last, done_w;
  assign pp     = a_q & {N{b_q[row_q]}};
  assign last   = row_q == CW'(N-1);
  assign done_w = state_q == DONE && !bus.abort;
  bw_row_gen #(.N(N), .CW(CW)) u_row_gen (.pp(pp), .row(row_q), .word(word));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    row_d   = row_q;
    prod_d  = prod_q;
    if (bus.abort) begin
      state_d = IDLE;
      row_d   = '0;
    end else if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = bus.b;
      acc_d   = '0;
      row_d   = '0;
    end else if (state_q == RUN) begin
      acc_d   = acc_q + ((2*N)'(word) << row_q);
      row_d   = last ? '0 : row_q + CW'(1);
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      prod_d  = acc_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      prod_q  <= prod_d;
    end
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = done_w;
  assign bus.product = done_w ? acc_q : prod_q;
  assign bus.row     = row_q;
endmodule
